// File: rtl/buzzer_melody_sequencer.sv
// Steps buzzer_pwm through a fixed melody table: period/duty/tone_on per note, silent gap after each entry.
// Optional: define BUZZER_SEQ_LOOP_EN to restart from entry 0 at end-of-song instead of pulsing done.
module buzzer_melody_sequencer #(
    parameter int N        = 32,
    parameter int BEAT_CYC = 12_500_000,
    parameter int GAP_CYC  = 500_000,
    parameter int NOTES    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic [1:0]   vol,
    output logic [N-1:0] period,
    output logic [N-1:0] duty,
    output logic         tone_on,
    output logic         busy,
    output logic         done,
    output logic [2:0]   note_idx
);

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(NOTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] period_q, period_d;
    logic [N-1:0] duty_q, duty_d;
    logic         tone_on_q, tone_on_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [2:0]   note_idx_q, note_idx_d;
    logic         wrapped_q, wrapped_d;
    logic [3:0]   beat_cnt_q, beat_cnt_d;
    logic [31:0]  cyc_cnt_q, cyc_cnt_d;

    logic [N-1:0] entry_inc;
    logic [3:0]   entry_beats;
    logic [N-1:0] vol_duty;

    // Melody table: phase increment (0 = rest) and length in beats (0 = end of song).
    always_comb begin
        entry_inc   = '0;
        entry_beats = '0;
        case (note_idx_q)
            3'd0: begin entry_inc = N'(44925); entry_beats = 4'd2; end
            3'd1: begin entry_inc = N'(50423); entry_beats = 4'd1; end
            3'd2: begin entry_inc = N'(56608); entry_beats = 4'd1; end
            3'd3: begin entry_inc = '0;        entry_beats = 4'd1; end
            3'd4: begin entry_inc = N'(67345); entry_beats = 4'd2; end
            default: ;
        endcase
    end

    always_comb begin
        vol_duty = '0;
        case (vol)
            2'd0: vol_duty = N'(64'd429496729);
            2'd1: vol_duty = N'(64'd858993459);
            2'd2: vol_duty = N'(64'd1288490188);
            2'd3: vol_duty = N'(64'd2147483648);
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        duty_d     = duty_q;
        tone_on_d  = tone_on_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        note_idx_d = note_idx_q;
        wrapped_d  = wrapped_q;
        beat_cnt_d = beat_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;

        // stop overrides everything; period/duty deliberately keep their last values
        if (stop && state_q != IDLE) begin
            state_d   = IDLE;
            tone_on_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d    = LOAD;
                        note_idx_d = '0;
                        wrapped_d  = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
                LOAD: begin
                    if (entry_beats == 4'd0 || wrapped_q) begin
`ifdef BUZZER_SEQ_LOOP_EN
                        note_idx_d = '0;
                        wrapped_d  = 1'b0;
`else
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        tone_on_d  = 1'b0;
                        wrapped_d  = 1'b0;
`endif
                    end else begin
                        state_d    = PLAY;
                        period_d   = entry_inc;
                        duty_d     = vol_duty;
                        tone_on_d  = (entry_inc != '0);
                        beat_cnt_d = entry_beats;
                        cyc_cnt_d  = '0;
                    end
                end
                PLAY: begin
                    if (cyc_cnt_q == BEAT_LAST) begin
                        cyc_cnt_d  = '0;
                        beat_cnt_d = beat_cnt_q - 4'd1;
                        if (beat_cnt_q <= 4'd1) begin
                            state_d   = GAP;
                            tone_on_d = 1'b0;
                        end
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 32'd1;
                    end
                end
                GAP: begin
                    if (cyc_cnt_q == GAP_LAST) begin
                        state_d    = LOAD;
                        cyc_cnt_d  = '0;
                        note_idx_d = note_idx_q + 3'd1;
                        wrapped_d  = (note_idx_q == LAST_IDX);
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            duty_q     <= '0;
            tone_on_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            note_idx_q <= '0;
            wrapped_q  <= 1'b0;
            beat_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            tone_on_q  <= tone_on_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            note_idx_q <= note_idx_d;
            wrapped_q  <= wrapped_d;
            beat_cnt_q <= beat_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign period   = period_q;
    assign duty     = duty_q;
    assign tone_on  = tone_on_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule
